// File: rtl/fft_pkg.sv
// Shared FFT pipeline constants, sample type and bit-reversal helpers.
// bitrev_n is width-generic so it can build elaborated permutations at any size.
package fft_pkg;

    localparam int N_FFT = 512;
    localparam int BATCH = 16;
    localparam int BW    = 12;
    localparam int IDX_W = 5;
    localparam int BEATS = N_FFT / BATCH;
    localparam int LOG2N = $clog2(N_FFT);

    // "real" is a reserved word, hence the short field names
    typedef struct packed {
        logic signed [BW-1:0] re;
        logic signed [BW-1:0] im;
        logic [IDX_W-1:0]     index;
    } sample_t;

    function automatic int bitrev_n(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder.sv
// Final FFT stage: buffers a bit-reversed frame in a ping-pong bank and
// replays it in natural order, BATCH samples per beat, with no back-pressure.
module fft_out_reorder #(
    parameter int N_FFT = fft_pkg::N_FFT,
    parameter int BATCH = fft_pkg::BATCH,
    parameter int BW    = fft_pkg::BW,
    parameter int IDX_W = fft_pkg::IDX_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [BW-1:0] real_in  [0:BATCH-1],
    input  logic signed [BW-1:0] imag_in  [0:BATCH-1],
    input  logic [IDX_W-1:0]     index_in [0:BATCH-1],
    input  logic                 in_valid,
    output logic signed [BW-1:0] real_out  [0:BATCH-1],
    output logic signed [BW-1:0] imag_out  [0:BATCH-1],
    output logic [IDX_W-1:0]     index_out [0:BATCH-1],
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eof
);

    localparam int BEATS = N_FFT / BATCH;
    localparam int LOG2N = $clog2(N_FFT);
    localparam int CW    = $clog2(BEATS);
    localparam int LW    = $clog2(BATCH);

    // One bank row holds a full input beat; position p = row*BATCH + lane
    logic [BATCH-1:0][BW-1:0]    r_bank_re [0:1][0:BEATS-1];
    logic [BATCH-1:0][BW-1:0]    r_bank_im [0:1][0:BEATS-1];
    logic [BATCH-1:0][IDX_W-1:0] r_bank_ix [0:1][0:BEATS-1];

    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic          r_rd_active;

    logic [BATCH-1:0][BW-1:0]    r_out_re;
    logic [BATCH-1:0][BW-1:0]    r_out_im;
    logic [BATCH-1:0][IDX_W-1:0] r_out_ix;
    logic                        r_out_valid;
    logic                        r_out_sof;
    logic                        r_out_eof;

    logic [BATCH-1:0][BW-1:0]    w_wr_re;
    logic [BATCH-1:0][BW-1:0]    w_wr_im;
    logic [BATCH-1:0][IDX_W-1:0] w_wr_ix;
    logic [BATCH-1:0][BW-1:0]    w_rd_re;
    logic [BATCH-1:0][BW-1:0]    w_rd_im;
    logic [BATCH-1:0][IDX_W-1:0] w_rd_ix;
    logic [LOG2N-1:0]            w_rd_addr [0:BEATS-1][0:BATCH-1];
    logic                        w_frame_done;
    logic                        w_last_rd;

    assign w_frame_done = in_valid && (r_wr_cnt == CW'(BEATS-1));
    assign w_last_rd    = r_rd_active && (r_rd_cnt == CW'(BEATS-1));

    // Constant permutation: output beat m lane l reads input position bitrev(m*BATCH+l)
    for (genvar m = 0; m < BEATS; m++) begin : g_perm_m
        for (genvar l = 0; l < BATCH; l++) begin : g_perm_l
            assign w_rd_addr[m][l] = LOG2N'(fft_pkg::bitrev_n(m*BATCH + l, LOG2N));
        end
    end

    for (genvar l = 0; l < BATCH; l++) begin : g_lane
        logic [LOG2N-1:0] w_addr;
        assign w_addr     = w_rd_addr[r_rd_cnt][l];
        assign w_wr_re[l] = real_in[l];
        assign w_wr_im[l] = imag_in[l];
        assign w_wr_ix[l] = index_in[l];
        assign w_rd_re[l] = r_bank_re[r_rd_bank][w_addr[LOG2N-1:LW]][w_addr[LW-1:0]];
        assign w_rd_im[l] = r_bank_im[r_rd_bank][w_addr[LOG2N-1:LW]][w_addr[LW-1:0]];
        assign w_rd_ix[l] = r_bank_ix[r_rd_bank][w_addr[LOG2N-1:LW]][w_addr[LW-1:0]];
        assign real_out[l]  = r_out_re[l];
        assign imag_out[l]  = r_out_im[l];
        assign index_out[l] = r_out_ix[l];
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_bank_re[r_wr_bank][r_wr_cnt] <= w_wr_re;
            r_bank_im[r_wr_bank][r_wr_cnt] <= w_wr_im;
            r_bank_ix[r_wr_bank][r_wr_cnt] <= w_wr_ix;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_active <= 1'b0;
        end else begin
            if (r_rd_active) begin
                r_rd_cnt <= r_rd_cnt + CW'(1);
                if (w_last_rd) begin
                    r_rd_active <= 1'b0;
                end
            end
            // Frame completion overrides the read-done clear so replay stays gapless
            if (in_valid) begin
                if (w_frame_done) begin
                    r_wr_cnt    <= '0;
                    r_wr_bank   <= ~r_wr_bank;
                    r_rd_bank   <= r_wr_bank;
                    r_rd_active <= 1'b1;
                    r_rd_cnt    <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_ix    <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (r_rd_active) begin
            r_out_re    <= w_rd_re;
            r_out_im    <= w_rd_im;
            r_out_ix    <= w_rd_ix;
            r_out_valid <= 1'b1;
            r_out_sof   <= (r_rd_cnt == '0);
            r_out_eof   <= w_last_rd;
        end else begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: frames are modelled as arrays indexed
// by input position and expected beats are derived from the bit-reversal rule.
module tb_fft_out_reorder;

    localparam int NB    = 16;
    localparam int NBEAT = 32;
    localparam int NF    = 512;

    logic              clk = 1'b0;
    logic              rstn;
    logic signed [11:0] real_in  [0:NB-1];
    logic signed [11:0] imag_in  [0:NB-1];
    logic [4:0]         index_in [0:NB-1];
    logic               in_valid;
    logic signed [11:0] real_out  [0:NB-1];
    logic signed [11:0] imag_out  [0:NB-1];
    logic [4:0]         index_out [0:NB-1];
    logic               out_valid;
    logic               out_sof;
    logic               out_eof;

    always #5 clk = ~clk;

    fft_out_reorder dut (
        .clk       (clk),
        .rstn      (rstn),
        .real_in   (real_in),
        .imag_in   (imag_in),
        .index_in  (index_in),
        .in_valid  (in_valid),
        .real_out  (real_out),
        .imag_out  (imag_out),
        .index_out (index_out),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    typedef struct packed {
        logic            sof;
        logic            eof;
        logic [15:0][11:0] re;
        logic [15:0][11:0] im;
        logic [15:0][4:0]  ix;
    } beat_t;

    beat_t cap_q[$];
    beat_t exp_q[$];
    int    cap_cyc[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_edge = 0;
    int    fr_re [NF];
    int    fr_im [NF];
    int    fr_ix [NF];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            beat_t b;
            b.sof = out_sof;
            b.eof = out_eof;
            for (int l = 0; l < NB; l++) begin
                b.re[l] = real_out[l];
                b.im[l] = imag_out[l];
                b.ix[l] = index_out[l];
            end
            cap_q.push_back(b);
            cap_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int br9(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 9; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (8 - i));
        end
        return r;
    endfunction

    task automatic clear_queues();
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    task automatic fill_ramp(input int off);
        for (int p = 0; p < NF; p++) begin
            fr_re[p] = p + off;
            fr_im[p] = -(p + off);
            fr_ix[p] = p % 32;
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < NF; p++) begin
            fr_re[p] = int'($urandom_range(0, 4095)) - 2048;
            fr_im[p] = int'($urandom_range(0, 4095)) - 2048;
            fr_ix[p] = int'($urandom_range(0, 31));
        end
    endtask

    task automatic push_expected();
        for (int m = 0; m < NBEAT; m++) begin
            beat_t b;
            int p;
            b.sof = (m == 0);
            b.eof = (m == NBEAT - 1);
            for (int l = 0; l < NB; l++) begin
                p = br9(m * NB + l);
                b.re[l] = 12'(fr_re[p]);
                b.im[l] = 12'(fr_im[p]);
                b.ix[l] = 5'(fr_ix[p]);
            end
            exp_q.push_back(b);
        end
    endtask

    // gap_mode: 0 contiguous, 1 one idle cycle per beat, 2 random 0..2 idle cycles
    task automatic drive_frame(input int nbeats, input int gap_mode);
        int gaps;
        for (int w = 0; w < nbeats; w++) begin
            for (int l = 0; l < NB; l++) begin
                real_in[l]  = 12'(fr_re[w * NB + l]);
                imag_in[l]  = 12'(fr_im[w * NB + l]);
                index_in[l] = 5'(fr_ix[w * NB + l]);
            end
            in_valid = 1'b1;
            @(posedge clk); #1;
            last_edge = cyc;
            in_valid = 1'b0;
            gaps = (gap_mode == 2) ? int'($urandom_range(0, 2)) : gap_mode;
            for (int g = 0; g < gaps; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_stream(input string name, input int first_edge);
        int budget;
        int n;
        beat_t last;
        budget = 0;
        while (cap_q.size() < exp_q.size() && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        checks++;
        if (cap_q.size() < exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d beats, expected %0d", name, cap_q.size(), exp_q.size());
        end
        n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_beat%0d: got %h expected %h", name, i, cap_q[i], exp_q[i]);
            end
            checks++;
            if (cap_cyc[i] !== first_edge + i) begin
                errors++;
                $display("FAIL %s_timing%0d: got edge %0d expected edge %0d", name, i, cap_cyc[i], first_edge + i);
            end
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_extra: got %0d beats, expected %0d", name, cap_q.size(), exp_q.size());
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_valid: got %b expected 0", name, out_valid);
        end
        if (exp_q.size() > 0) begin
            last = exp_q[exp_q.size() - 1];
            for (int l = 0; l < NB; l++) begin
                checks++;
                if (real_out[l] !== last.re[l] || imag_out[l] !== last.im[l] || index_out[l] !== last.ix[l]) begin
                    errors++;
                    $display("FAIL %s_hold lane%0d: got %h/%h/%h expected %h/%h/%h", name, l,
                             real_out[l], imag_out[l], index_out[l], last.re[l], last.im[l], last.ix[l]);
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b%b%b expected 000", out_valid, out_sof, out_eof);
        end
        for (int l = 0; l < NB; l++) begin
            checks++;
            if (real_out[l] !== 12'd0 || imag_out[l] !== 12'd0 || index_out[l] !== 5'd0) begin
                errors++;
                $display("FAIL reset_data lane%0d: got %h/%h/%h expected 0/0/0", l, real_out[l], imag_out[l], index_out[l]);
            end
        end
    endtask

    task automatic test_ramp();
        clear_queues();
        fill_ramp(0);
        push_expected();
        drive_frame(NBEAT, 0);
        check_stream("ramp", last_edge + 1);
        if (cap_q.size() >= 2) begin
            checks++;
            if (cap_q[0].re[0] !== 12'd0 || cap_q[0].re[1] !== 12'd256 ||
                cap_q[0].re[2] !== 12'd128 || cap_q[0].re[3] !== 12'd384) begin
                errors++;
                $display("FAIL ramp_beat0_lanes: got %0d %0d %0d %0d expected 0 256 128 384",
                         cap_q[0].re[0], cap_q[0].re[1], cap_q[0].re[2], cap_q[0].re[3]);
            end
            checks++;
            if (cap_q[1].re[0] !== 12'd16) begin
                errors++;
                $display("FAIL ramp_beat1_lane0: got %0d expected 16", cap_q[1].re[0]);
            end
            checks++;
            if (cap_q[0].im[1] !== 12'hF00 || cap_q[0].ix[1] !== 5'd0) begin
                errors++;
                $display("FAIL ramp_imag_index: got %h/%h expected f00/00", cap_q[0].im[1], cap_q[0].ix[1]);
            end
        end
    endtask

    task automatic test_gapped();
        clear_queues();
        fill_ramp(0);
        push_expected();
        drive_frame(NBEAT, 1);
        check_stream("gapped", last_edge + 1);
    endtask

    task automatic test_back_to_back();
        int offs [3];
        int first;
        offs[0] = 0;
        offs[1] = 1000;
        offs[2] = -1000;
        first = 0;
        clear_queues();
        for (int k = 0; k < 3; k++) begin
            fill_ramp(offs[k]);
            push_expected();
            drive_frame(NBEAT, 0);
            if (k == 0) first = last_edge + 1;
        end
        check_stream("b2b", first);
    endtask

    task automatic test_extreme();
        clear_queues();
        for (int p = 0; p < NF; p++) begin
            fr_re[p] = -2048;
            fr_im[p] = 2047;
            fr_ix[p] = 31;
        end
        push_expected();
        drive_frame(NBEAT, 0);
        check_stream("extreme", last_edge + 1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            clear_queues();
            fill_random();
            push_expected();
            drive_frame(NBEAT, 2);
            check_stream($sformatf("random%0d", f), last_edge + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_queues();
        fill_ramp(500);
        drive_frame(10, 0);
        rstn = 1'b0;
        #2;
        test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        clear_queues();
        fill_random();
        push_expected();
        drive_frame(NBEAT, 0);
        check_stream("midframe", last_edge + 1);
    endtask

    task automatic test_reset_mid_read();
        int budget;
        clear_queues();
        fill_random();
        push_expected();
        drive_frame(NBEAT, 0);
        budget = 0;
        while (cap_q.size() < 6 && budget < 100) begin
            @(negedge clk); #1;
            budget++;
        end
        checks++;
        if (cap_q.size() != 6) begin
            errors++;
            $display("FAIL midread_reach_beat5: got %0d beats, expected 6", cap_q.size());
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sof !== 1'b0 || out_eof !== 1'b0 || real_out[3] !== 12'd0) begin
            errors++;
            $display("FAIL midread_async: got valid=%b sof=%b eof=%b re3=%h expected 0", out_valid, out_sof, out_eof, real_out[3]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (45) begin @(posedge clk); #1; end
        checks++;
        if (cap_q.size() != 6) begin
            errors++;
            $display("FAIL midread_no_more: got %0d beats, expected 6", cap_q.size());
        end
        if (cap_q.size() >= 6) begin
            checks++;
            if (cap_q[5] !== exp_q[5]) begin
                errors++;
                $display("FAIL midread_beat5: got %h expected %h", cap_q[5], exp_q[5]);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0;
        for (int l = 0; l < NB; l++) begin
            real_in[l]  = '0;
            imag_in[l]  = '0;
            index_in[l] = '0;
        end
        repeat (3) begin @(posedge clk); #1; end
        test_reset();
        rstn = 1'b1;
        @(posedge clk); #1;
        test_ramp();
        test_gapped();
        test_back_to_back();
        test_extreme();
        test_random();
        test_reset_mid_frame();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Final output stage of the 512-point FFT pipeline. It sits directly downstream of the last CBFP normalisation stage and consumes its 16-sample-per-beat, bit-reversed-order output: 12-bit real/imag samples plus a 5-bit block exponent per sample. It buffers one complete frame in a ping-pong register bank and replays it in natural frequency order, 16 samples per beat, at full throughput with no back-pressure.

## Interface
Parameters:
- N_FFT, 512, points per frame (power of two)
- BATCH, 16, samples per beat
- BW, 12, sample width (signed)
- IDX_W, 5, block-exponent width
- Derived, not overridable: BEATS = N_FFT/BATCH = 32; LOG2N = 9

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- real_in[0:BATCH-1]  in  BW signed  real samples, bit-reversed order
- imag_in[0:BATCH-1]  in  BW signed  imaginary samples
- index_in[0:BATCH-1]  in  IDX_W  per-sample block exponent
- in_valid  in  1  beat qualifier
- real_out[0:BATCH-1]  out  BW signed  real samples, natural order
- imag_out[0:BATCH-1]  out  BW signed  imaginary samples
- index_out[0:BATCH-1]  out  IDX_W  exponent travelling with each sample
- out_valid  out  1  output beat qualifier
- out_sof  out  1  high with output beat 0 of each frame
- out_eof  out  1  high with output beat BEATS-1

## Operation
- Input position of lane l in write beat w: p = w*BATCH + l. Output beat m, lane l carries the sample whose input position is bitrev_LOG2N(m*BATCH + l), together with its real, imag and index.
- Two banks of N_FFT entries, each holding {real, imag, index}. wr_bank and rd_bank pointers; wr_cnt 0..BEATS-1; rd_cnt 0..BEATS-1; rd_active flag.
- Write: on each in_valid beat, write all lanes to wr_bank at row wr_cnt, then increment wr_cnt. On the beat with wr_cnt = BEATS-1: wrap wr_cnt to 0, toggle wr_bank, set rd_active, set rd_cnt = 0, and point rd_bank at the just-filled bank.
- in_valid gaps are allowed anywhere. The write counter holds while in_valid = 0, and no data is lost.
- Read: while rd_active, each cycle register one output beat from rd_bank using rd_cnt and increment rd_cnt. After beat BEATS-1, clear rd_active.
- Collision-free by construction. Input accepts at most one beat per cycle, so the next frame completes no earlier than 32 cycles after the previous one. By then the read has finished.
- Simultaneous events: the last read beat of frame k and the completion of frame k+1 in the same cycle is legal. Output stays continuous (out_valid never drops), and out_sof of frame k+1 follows out_eof of frame k directly.
- No saturation or arithmetic. Data and index pass through bit-exact.
- Reset, including mid-frame or mid-read: all counters 0, wr_bank = 0, rd_active = 0, and all outputs 0. A partially written frame is discarded. Bank contents need not be reset.

## Timing
- Reset values: real_out, imag_out and index_out all 0; out_valid, out_sof and out_eof all 0.
- Latency: if the frame's last input beat is captured on edge t, output beat 0 is registered on edge t+1. Beats 1..31 follow on edges t+2..t+32, with out_valid held high continuously for 32 cycles.
- out_sof is high only with beat 0. out_eof is high only with beat 31.
- When out_valid = 0, data outputs hold their last value.

## Structure
- Shared package fft_pkg holds:
  - N_FFT, BATCH, BW, IDX_W, BEATS, LOG2N constants.
  - A sample_t struct {real, imag, index}.
  - A bitrev function of LOG2N bits, so that other stages can reuse it.
- No sub-module is needed. The read-address mapping is an elaborated constant permutation, a generate over m and l using bitrev.

## Test plan
- Ramp frame: 32 contiguous beats with real = p, imag = -p, index = p mod 32. Required output:
  - Beat 0 lanes 0..3 real = 0, 256, 128, 384.
  - Beat 1 lane 0 real = 16.
  - Every imag = -real, and every index = real mod 32.
  - out_valid rises exactly 1 edge after the last input beat.
- Back-to-back frames: 3 ramp frames with offsets 0, 1000 and -1000 and no input gap. Required: out_valid stays high for 96 consecutive cycles, with out_sof/out_eof pulses at cycles 0/31, 32/63 and 64/95.
- Gapped input: one idle cycle after every input beat. Required: output identical to the ramp test, starting 1 edge after beat 31.
- Reset mid-frame: assert rstn low after 10 input beats, then send a full frame. Required: all outputs are 0 during reset, and only the post-reset frame is emitted.
- Reset mid-read: assert rstn low during output beat 5. Required: out_valid falls immediately (asynchronous reset) and no further beats are emitted.
- Extreme values: real = -2048 and imag = 2047 in all lanes, index = 31. Required: bit-exact pass-through to every lane.
